pixel_readout_ctrl: RTL and testbench
=====================================

# pixel_readout_ctrl

Sequencer for the analog-to-digital conversion and pixel-bus readout of the pixel array. It follows the erase/expose/convert/read phase strobes produced by the array phase controller. During CONVERT it generates the digital ramp code and ramp step pulses. During READ it selects each pixel onto the shared data bus in turn, captures the value and delivers it downstream over a valid/ready handshake. It also reports frame completion and read-window overruns.

## Interface
- N_PIX, default 4: number of pixels sharing the data bus.
- DW, default 8: ADC code and pixel data width.
- SETTLE, default 1: cycles from a bus-select change to sampling, range 1..15.
- clk  in  1  clock; all logic on posedge.
- reset  in  1  asynchronous, active-high.
- expose  in  1  phase strobe from the array phase controller.
- convert  in  1  phase strobe.
- read  in  1  phase strobe.
- pix_data  in  DW  shared pixel data bus.
- out_ready  in  1  downstream ready.
- ana_bias_en  out  1  bias enable; equals registered expose.
- ramp_step  out  1  one-cycle pulse for each ramp increment.
- dac_code  out  DW  digital ramp code driven to the pixel comparators.
- bus_sel  out  N_PIX  one-hot pixel bus-drive enable; 0 when idle.
- out_valid  out  1  output beat valid.
- out_data  out  DW  captured pixel value.
- out_idx  out  $clog2(N_PIX)  pixel index of the current beat.
- frame_done  out  1  one-cycle pulse after the last pixel is accepted.
- overrun  out  1  sticky flag: read window closed before readout finished.

## Operation
- Reset values: all outputs 0. State is IDLE and the pixel index is 0.
- The phase strobes are registered once internally (r_expose, r_convert, r_read). All decisions use the registered copies. Edge detection compares each registered copy with its previous value.
- ana_bias_en = r_expose.
- Ramp generation:
  - On the rising edge of r_convert, dac_code is cleared to 0.
  - While r_convert=1, dac_code increments by 1 each cycle and ramp_step pulses on that cycle.
  - dac_code saturates at 2^DW-1; it never wraps. ramp_step stays 0 once saturated.
  - When r_convert=0, dac_code holds its value and ramp_step=0.
- Readout states: IDLE -> SELECT -> SAMPLE -> OFFER -> (SELECT of the next pixel | DONE) -> IDLE.
  - IDLE: on the rising edge of r_read, set idx=0 and go to SELECT.
  - SELECT: bus_sel = 1<<idx. Wait SETTLE cycles, then go to SAMPLE.
  - SAMPLE: capture pix_data into out_data, set out_idx=idx, assert out_valid. bus_sel stays asserted for this cycle only. Go to OFFER.
  - OFFER: out_valid is held and out_data/out_idx are held stable until out_ready=1. On the handshake, if idx==N_PIX-1 go to DONE; otherwise increment idx and go to SELECT.
  - DONE: pulse frame_done for one cycle, then go to IDLE.
- Handshake:
  - A beat transfers on a cycle with out_valid & out_ready.
  - out_valid never drops without a transfer, except on an abort or reset.
  - out_ready may be high before out_valid.
- Overrun:
  - If r_read falls while the state is SELECT, SAMPLE or OFFER, set overrun.
  - Deassert out_valid and bus_sel, go to IDLE, and do not pulse frame_done.
  - overrun is cleared only by reset.
- If r_convert and r_read are both high, or a read edge arrives mid-readout, the ramp runs independently. A second r_read rising edge while not in IDLE is ignored.

## Timing
- Strobe to effect: 1 cycle. For example, expose rises at posedge N and ana_bias_en rises at posedge N+1.
- The first ramp_step occurs at posedge N+2 after convert is sampled high at N. dac_code=1 after the first step.
- Per pixel: SELECT takes SETTLE cycles, SAMPLE 1 cycle, OFFER at least 1 cycle. With out_ready tied high, one pixel takes SETTLE+2 cycles.
- A frame of N_PIX=4 with SETTLE=1 and out_ready=1: frame_done pulses 12 cycles after the registered read edge.
- Asynchronous reset mid-operation immediately zeroes all outputs, including the sticky overrun flag.

## Test plan
- Reset asserted mid-OFFER with out_valid=1 -> all outputs 0 asynchronously, state IDLE, and no frame_done after release.
- convert held high for 300 cycles with DW=8 -> dac_code steps 0..255, exactly 255 ramp_step pulses, then holds at 255 with no wrap. A second convert edge restarts from 0.
- read held high for 50 cycles, pix_data driven as 0x11/0x22/0x33/0x44 per bus_sel, out_ready=1 -> 4 beats with out_idx 0..3 carrying those values, bus_sel one-hot per beat, one frame_done pulse, overrun=0.
- Same stimulus with out_ready low for 5 cycles during beat 2 -> out_valid, out_data=0x33 and out_idx=2 held stable across the stall. Beat 2 transfers exactly once and no beat is lost.
- read dropped after 4 cycles -> overrun=1 and stays 1, out_valid=0, bus_sel=0, no frame_done. The next read window completes all 4 beats with overrun still 1.
- expose pulse of 3 cycles -> ana_bias_en high for exactly 3 cycles, delayed by 1 cycle.

Source files
------------

// File: rtl/pixel_readout_ctrl.sv
// pixel_readout_ctrl: ramp generation during CONVERT and sequential
// pixel-bus readout during READ, with a valid/ready output stream,
// frame-completion pulse and sticky read-window overrun flag.
module pixel_readout_ctrl #(
    parameter int N_PIX  = 4,
    parameter int DW     = 8,
    parameter int SETTLE = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       expose,
    input  logic                       convert,
    input  logic                       read,
    input  logic [DW-1:0]              pix_data,
    input  logic                       out_ready,
    output logic                       ana_bias_en,
    output logic                       ramp_step,
    output logic [DW-1:0]              dac_code,
    output logic [N_PIX-1:0]           bus_sel,
    output logic                       out_valid,
    output logic [DW-1:0]              out_data,
    output logic [$clog2(N_PIX)-1:0]   out_idx,
    output logic                       frame_done,
    output logic                       overrun
);

    localparam int                 IW          = $clog2(N_PIX);
    localparam logic [IW-1:0]      LAST_IDX    = IW'(N_PIX - 1);
    localparam logic [3:0]         SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [N_PIX-1:0]   SEL_FIRST   = N_PIX'(1);

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        SAMPLE,
        OFFER,
        DONE
    } state_t;

    state_t        state, next_state;
    logic [IW-1:0] idx, idx_next;
    logic [3:0]    settle_cnt, settle_next;
    logic          abort;

    logic r_expose, r_convert, r_read;
    logic r_convert_d, r_read_d;
    logic conv_rise, read_rise, read_fall;

    // Register the phase strobes once, plus a delayed copy for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_expose    <= 1'b0;
            r_convert   <= 1'b0;
            r_read      <= 1'b0;
            r_convert_d <= 1'b0;
            r_read_d    <= 1'b0;
        end else begin
            r_expose    <= expose;
            r_convert   <= convert;
            r_read      <= read;
            r_convert_d <= r_convert;
            r_read_d    <= r_read;
        end
    end

    assign conv_rise   = r_convert & ~r_convert_d;
    assign read_rise   = r_read & ~r_read_d;
    assign read_fall   = ~r_read & r_read_d;
    assign ana_bias_en = r_expose;

    // Ramp: clear on convert rise, then count up once per cycle until saturated
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dac_code  <= '0;
            ramp_step <= 1'b0;
        end else if (conv_rise) begin
            dac_code  <= '0;
            ramp_step <= 1'b0;
        end else if (r_convert && (dac_code != '1)) begin
            dac_code  <= dac_code + 1'b1;
            ramp_step <= 1'b1;
        end else begin
            ramp_step <= 1'b0;
        end
    end

    // Readout state, pixel index and settle counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= '0;
            settle_cnt <= '0;
        end else begin
            state      <= next_state;
            idx        <= idx_next;
            settle_cnt <= settle_next;
        end
    end

    // Next-state logic and per-state outputs; a read-window close mid-frame aborts
    always_comb begin
        next_state  = state;
        idx_next    = idx;
        settle_next = '0;
        abort       = 1'b0;
        bus_sel     = '0;
        out_valid   = 1'b0;
        frame_done  = 1'b0;
        case (state)
            IDLE: begin
                if (read_rise) begin
                    idx_next   = '0;
                    next_state = SELECT;
                end
            end
            SELECT: begin
                bus_sel = SEL_FIRST << idx;
                if (settle_cnt == SETTLE_LAST) begin
                    next_state = SAMPLE;
                end else begin
                    settle_next = settle_cnt + 1'b1;
                end
            end
            SAMPLE: begin
                bus_sel    = SEL_FIRST << idx;
                next_state = OFFER;
            end
            OFFER: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (idx == LAST_IDX) begin
                        next_state = DONE;
                    end else begin
                        idx_next   = idx + 1'b1;
                        next_state = SELECT;
                    end
                end
            end
            DONE: begin
                frame_done = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
        // Abort wins over a same-cycle handshake: the frame is discarded
        if (read_fall && (state == SELECT || state == SAMPLE || state == OFFER)) begin
            abort       = 1'b1;
            next_state  = IDLE;
            idx_next    = idx;
            settle_next = '0;
        end
    end

    // Capture the selected pixel at the end of SAMPLE; held through OFFER
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data <= '0;
            out_idx  <= '0;
        end else if (state == SAMPLE) begin
            out_data <= pix_data;
            out_idx  <= idx;
        end
    end

    // Sticky overrun flag, cleared only by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (abort) begin
            overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pixel_readout_ctrl.sv
// Testbench for pixel_readout_ctrl: vector table for strobe/ramp timing,
// directed readout sequences, randomized windows against a frame-level model.
module tb_pixel_readout_ctrl;

    localparam int NP = 4;

    logic       clk = 1'b0;
    logic       reset, expose, convert, read, out_ready;
    logic [7:0] pix_data;
    logic       ana_bias_en, ramp_step, out_valid, frame_done, overrun;
    logic [7:0] dac_code, out_data;
    logic [3:0] bus_sel;
    logic [1:0] out_idx;

    pixel_readout_ctrl #(.N_PIX(NP), .DW(8), .SETTLE(1)) dut (
        .clk(clk), .reset(reset), .expose(expose), .convert(convert),
        .read(read), .pix_data(pix_data), .out_ready(out_ready),
        .ana_bias_en(ana_bias_en), .ramp_step(ramp_step), .dac_code(dac_code),
        .bus_sel(bus_sel), .out_valid(out_valid), .out_data(out_data),
        .out_idx(out_idx), .frame_done(frame_done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Pixel array model: each pixel drives its value only when selected
    logic [7:0] pix_val [NP];
    always_comb begin
        pix_data = 8'hEE;
        for (int i = 0; i < NP; i++)
            if (bus_sel == (4'b0001 << i)) pix_data = pix_val[i];
    end

    // ------------------------------------------------------------------
    // Reference model, evaluated mid-cycle. Inputs change 1ns after posedge,
    // so the value seen at a negedge is what the next edge registers.
    // ------------------------------------------------------------------
    localparam int P_IDLE = 0, P_BUSY = 1, P_DONE = 2;
    logic last_read, prev_read, last_conv, last_expose;
    int   conv_run;      // consecutive cycles r_convert has been high
    int   dac_hold;      // ramp value left behind by the previous run
    int   phase, exp_next, beats, frames;
    logic overrun_exp;
    int   exp_dac;

    initial begin
        last_read = 0; prev_read = 0; last_conv = 0; last_expose = 0;
        conv_run = 0; dac_hold = 0; phase = P_IDLE; exp_next = 0;
        beats = 0; frames = 0; overrun_exp = 0;
    end

    always @(negedge clk) begin
        if (reset) begin
            last_read = 0; prev_read = 0; last_conv = 0; last_expose = 0;
            conv_run = 0; dac_hold = 0; phase = P_IDLE; exp_next = 0;
            overrun_exp = 0;
        end else begin
            if (frame_done) frames++;
            if (out_valid && out_ready) beats++;
            // bias follows expose; ramp value = run length - 1, capped at 255
            check("ana_bias_en", ana_bias_en, last_expose);
            exp_dac = (conv_run == 0) ? dac_hold : ((conv_run - 1 > 255) ? 255 : conv_run - 1);
            check("dac_code", dac_code, exp_dac);
            check("ramp_step", ramp_step, (conv_run >= 2 && conv_run <= 256));
            if (last_conv) conv_run++;
            else begin
                if (conv_run > 0) dac_hold = (conv_run - 1 > 255) ? 255 : conv_run - 1;
                conv_run = 0;
            end
            check("overrun", overrun, overrun_exp);
            case (phase)
                P_IDLE: begin
                    check("idle_frame_done", frame_done, 0);
                    check("idle_valid", out_valid, 0);
                    check("idle_bus_sel", bus_sel, 0);
                    if (last_read && !prev_read) begin
                        phase = P_BUSY;
                        exp_next = 0;
                    end
                end
                P_BUSY: begin
                    check("busy_frame_done", frame_done, 0);
                    check("sel_xor_valid", (bus_sel != 0) ^ out_valid, 1);
                    if (bus_sel != 0) check("bus_sel", bus_sel, 4'b0001 << exp_next);
                    if (out_valid) begin
                        check("out_idx", out_idx, exp_next);
                        check("out_data", out_data, pix_val[exp_next]);
                    end
                    if (!last_read && prev_read) begin
                        overrun_exp = 1;
                        phase = P_IDLE;
                    end else if (out_valid && out_ready) begin
                        exp_next++;
                        if (exp_next == NP) phase = P_DONE;
                    end
                end
                default: begin
                    check("done_frame_done", frame_done, 1);
                    check("done_valid", out_valid, 0);
                    check("done_bus_sel", bus_sel, 0);
                    phase = P_IDLE;
                end
            endcase
            prev_read   = last_read;
            last_read   = read;
            last_conv   = convert;
            last_expose = expose;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       expose;
        logic       convert;
        logic       exp_ana;
        logic       exp_step;
        logic [7:0] exp_dac;
    } vec_t;
    vec_t vecs [12];

    int b0, f0, t_sel, t_done, nsteps;
    logic found, wrapped, seen_max;

    initial begin
        // inputs are sampled at the edge following each row; outputs compared after it
        vecs = '{
            '{1'b1, 1'b0, 1'b1, 1'b0, 8'd0},
            '{1'b1, 1'b0, 1'b1, 1'b0, 8'd0},
            '{1'b1, 1'b0, 1'b1, 1'b0, 8'd0},
            '{1'b0, 1'b1, 1'b0, 1'b0, 8'd0},
            '{1'b0, 1'b1, 1'b0, 1'b0, 8'd0},
            '{1'b0, 1'b1, 1'b0, 1'b1, 8'd1},
            '{1'b0, 1'b0, 1'b0, 1'b1, 8'd2},
            '{1'b0, 1'b0, 1'b0, 1'b0, 8'd2},
            '{1'b0, 1'b1, 1'b0, 1'b0, 8'd2},
            '{1'b0, 1'b1, 1'b0, 1'b0, 8'd0},
            '{1'b0, 1'b0, 1'b0, 1'b1, 8'd1},
            '{1'b0, 1'b0, 1'b0, 1'b0, 8'd1}
        };
        pix_val = '{8'h11, 8'h22, 8'h33, 8'h44};
        reset = 1; expose = 0; convert = 0; read = 0; out_ready = 0;
        repeat (3) step();
        check("rst_ana", ana_bias_en, 0);
        check("rst_step", ramp_step, 0);
        check("rst_dac", dac_code, 0);
        check("rst_bus_sel", bus_sel, 0);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_idx", out_idx, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_overrun", overrun, 0);
        reset = 0;
        step();

        // expose pulse and short ramp runs
        for (int i = 0; i < 12; i++) begin
            expose  = vecs[i].expose;
            convert = vecs[i].convert;
            step();
            check($sformatf("vec%0d_ana", i), ana_bias_en, vecs[i].exp_ana);
            check($sformatf("vec%0d_step", i), ramp_step, vecs[i].exp_step);
            check($sformatf("vec%0d_dac", i), dac_code, vecs[i].exp_dac);
        end

        // long convert: 255 steps then saturation without wrap
        convert = 1; nsteps = 0; wrapped = 0; seen_max = 0;
        repeat (300) begin
            step();
            if (ramp_step) nsteps++;
            if (seen_max && dac_code != 8'hFF) wrapped = 1;
            if (dac_code == 8'hFF) seen_max = 1;
        end
        check("sat_steps", nsteps, 255);
        check("sat_dac", dac_code, 8'hFF);
        check("sat_nowrap", wrapped, 0);
        convert = 0;
        repeat (3) step();
        check("sat_hold", dac_code, 8'hFF);
        convert = 1;
        step(); step();
        check("restart_dac0", dac_code, 0);
        step();
        check("restart_dac1", dac_code, 1);
        check("restart_step", ramp_step, 1);
        convert = 0;
        repeat (3) step();

        // full frame, ready tied high; frame_done 12 cycles after the FSM takes the read edge
        out_ready = 1; read = 1; t_sel = -1; t_done = -1; b0 = beats; f0 = frames;
        for (int k = 0; k < 50; k++) begin
            step();
            if (bus_sel != 0 && t_sel < 0) t_sel = k;
            if (frame_done) t_done = k;
        end
        read = 0;
        repeat (5) step();
        check("frame_beats", beats - b0, 4);
        check("frame_count", frames - f0, 1);
        check("first_select", t_sel, 1);
        check("frame_latency", t_done - t_sel, 12);
        check("frame_overrun", overrun, 0);

        // stall beat 2 for 5 cycles
        read = 1; out_ready = 1; found = 0; b0 = beats; f0 = frames;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus_sel == 4'b0100) begin
                found = 1;
                break;
            end
        end
        check("stall_found_pix2", found, 1);
        out_ready = 0;
        step(); step();
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", out_valid, 1);
            check("stall_data", out_data, 8'h33);
            check("stall_idx", out_idx, 2);
            step();
        end
        out_ready = 1;
        repeat (40) step();
        read = 0;
        repeat (5) step();
        check("stall_beats", beats - b0, 4);
        check("stall_frames", frames - f0, 1);

        // randomized read windows, ready and convert against the model
        for (int w = 0; w < 30; w++) begin
            for (int i = 0; i < NP; i++) pix_val[i] = 8'($urandom);
            read = 1;
            repeat ($urandom_range(3, 40)) begin
                out_ready = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 7) == 0) convert = ~convert;
                expose = 1'($urandom);
                step();
            end
            read = 0;
            repeat (4) begin
                out_ready = 1'($urandom);
                step();
            end
        end
        convert = 0; expose = 0;
        pix_val = '{8'h11, 8'h22, 8'h33, 8'h44};
        repeat (3) step();

        // read window closes after 4 cycles, then a complete window
        out_ready = 1; read = 1; f0 = frames;
        repeat (4) step();
        read = 0;
        repeat (6) step();
        check("ovr_flag", overrun, 1);
        check("ovr_valid", out_valid, 0);
        check("ovr_bus_sel", bus_sel, 0);
        check("ovr_no_done", frames - f0, 0);
        read = 1; b0 = beats; f0 = frames;
        repeat (50) step();
        read = 0;
        repeat (5) step();
        check("ovr_next_beats", beats - b0, 4);
        check("ovr_next_frames", frames - f0, 1);
        check("ovr_sticky", overrun, 1);

        // asynchronous reset while a beat is offered
        read = 1; out_ready = 0; found = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (out_valid) begin
                found = 1;
                break;
            end
        end
        check("arst_found_offer", found, 1);
        #2 reset = 1; read = 0;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_data", out_data, 0);
        check("arst_idx", out_idx, 0);
        check("arst_bus_sel", bus_sel, 0);
        check("arst_overrun", overrun, 0);
        check("arst_dac", dac_code, 0);
        check("arst_frame_done", frame_done, 0);
        step(); step();
        reset = 0; f0 = frames;
        repeat (10) step();
        check("post_rst_no_done", frames - f0, 0);
        check("post_rst_valid", out_valid, 0);
        check("post_rst_overrun", overrun, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
